// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read channel between the system-ID checker (master) and the sysid slave.
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
  modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID checker: reads ID and timestamp words, compares against
// build-time values, retries on mismatch and reports pass/fail/timeout.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h6225_A104,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          MAX_RETRY    = 2,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  sysid_check_ctrl_if.master avm,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               err_id,
  output logic               err_ts,
  output logic               err_timeout,
  output logic [31:0]        id_value,
  output logic [31:0]        ts_value
);
  typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, DONE} state_t;

  localparam bit          LAT0      = (READ_LATENCY == 0);
  localparam logic [1:0]  LAT_INIT  = 2'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      state;
  logic [3:0]  retry_cnt;
  logic [15:0] tmo_cnt;
  logic [1:0]  lat_cnt;
  logic        auto_arm;
  logic        id_ok, ts_ok;

  assign id_ok = (id_value == EXPECTED_ID);
  assign ts_ok = (ts_value == EXPECTED_TS);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      retry_cnt       <= '0;
      tmo_cnt         <= '0;
      lat_cnt         <= '0;
      auto_arm        <= AUTO_START;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_id          <= 1'b0;
      err_ts          <= 1'b0;
      err_timeout     <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start || auto_arm) begin
          state           <= RD_ID;
          avm.avm_read    <= 1'b1;
          avm.avm_address <= 1'b0;
          busy            <= 1'b1;
          pass            <= 1'b0;
          err_id          <= 1'b0;
          err_ts          <= 1'b0;
          err_timeout     <= 1'b0;
          retry_cnt       <= '0;
          tmo_cnt         <= '0;
          auto_arm        <= 1'b0;
        end
        RD_ID, RD_TS: begin
          if (avm.avm_waitrequest) begin
            tmo_cnt <= tmo_cnt + 16'd1;
            // A stuck slave is a hard failure; retrying would only stall boot longer.
            if (tmo_cnt == TMO_LAST) begin
              avm.avm_read <= 1'b0;
              err_timeout  <= 1'b1;
              pass         <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end
          end else begin
            tmo_cnt <= '0;
            if (LAT0) begin
              if (state == RD_ID) begin
                id_value        <= avm.avm_readdata;
                avm.avm_address <= 1'b1;
                state           <= RD_TS;
              end else begin
                ts_value     <= avm.avm_readdata;
                avm.avm_read <= 1'b0;
                state        <= CHECK;
              end
            end else begin
              avm.avm_read <= 1'b0;
              lat_cnt      <= LAT_INIT;
              state        <= (state == RD_ID) ? LAT_ID : LAT_TS;
            end
          end
        end
        LAT_ID, LAT_TS: begin
          if (lat_cnt == 2'd0) begin
            if (state == LAT_ID) begin
              id_value        <= avm.avm_readdata;
              avm.avm_read    <= 1'b1;
              avm.avm_address <= 1'b1;
              state           <= RD_TS;
            end else begin
              ts_value <= avm.avm_readdata;
              state    <= CHECK;
            end
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        CHECK: begin
          err_id <= !id_ok;
          err_ts <= !ts_ok;
          if (id_ok && ts_ok) begin
            pass  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt       <= retry_cnt + 4'd1;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            state           <= RD_ID;
          end else begin
            pass  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Bench for sysid_check_ctrl: two instances (READ_LATENCY 0 and 2) against a
// behavioural sysid slave, table-driven sequences checked through a scoreboard.
module tb_sysid_check_ctrl;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h6225_A104;
  localparam logic [31:0] BAD_ID = 32'h0000_0001;
  localparam logic [31:0] BAD_TS = 32'h1234_5678;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  typedef struct {
    int inst; int id_bad; int ts_bad; int st_id; int st_ts;
    bit pass; bit eid; bit ets; bit etmo; int pairs; bit chkv;
    logic [31:0] idv; logic [31:0] tsv;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  logic        start [2];
  logic        busy [2], done [2], pass [2], err_id [2], err_ts [2], err_timeout [2];
  logic [31:0] id_value [2], ts_value [2];
  logic        rd [2], addr [2], wr [2];
  logic [31:0] rdata [2];

  int id_bad [2], ts_bad [2], st_id [2], st_ts [2], base [2];
  int id_reads [2], st_cnt [2], pend [2];
  logic [31:0] pdata [2];

  int n_chk = 0;
  int n_fail = 0;
  vec_t sb [$];
  vec_t tbl [$];

  sysid_check_ctrl_if bus0 ();
  sysid_check_ctrl_if bus1 ();

  assign bus0.avm_readdata    = rdata[0];
  assign bus0.avm_waitrequest = wr[0];
  assign bus1.avm_readdata    = rdata[1];
  assign bus1.avm_waitrequest = wr[1];
  assign rd[0]   = bus0.avm_read;
  assign addr[0] = bus0.avm_address;
  assign rd[1]   = bus1.avm_read;
  assign addr[1] = bus1.avm_address;

  sysid_check_ctrl u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .avm(bus0),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_id(err_id[0]),
    .err_ts(err_ts[0]), .err_timeout(err_timeout[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0])
  );

  sysid_check_ctrl #(.READ_LATENCY(2)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .avm(bus1),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_id(err_id[1]),
    .err_ts(err_ts[1]), .err_timeout(err_timeout[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int inst, input int ib, input int tb_, input int si, input int st,
                              input bit p, input bit ei, input bit et, input bit eto, input int pairs,
                              input bit cv, input logic [31:0] iv, input logic [31:0] tv);
    vec_t v;
    v.inst = inst; v.id_bad = ib; v.ts_bad = tb_; v.st_id = si; v.st_ts = st;
    v.pass = p; v.eid = ei; v.ets = et; v.etmo = eto; v.pairs = pairs;
    v.chkv = cv; v.idv = iv; v.tsv = tv;
    return v;
  endfunction

  function automatic int rl(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  task automatic set_cfg(input int i, input int ib, input int tb_, input int si, input int st);
    id_bad[i] = ib; ts_bad[i] = tb_; st_id[i] = si; st_ts[i] = st;
    base[i] = id_reads[i];
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("wait_done_budget", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v);
    set_cfg(v.inst, v.id_bad, v.ts_bad, v.st_id, v.st_ts);
    sb.push_back(v);
    @(negedge clock);
    start[v.inst] = 1'b1;
    @(negedge clock);
    start[v.inst] = 1'b0;
    wait_idle(3000);
  endtask

  // Behavioural sysid slave: per-address stall count, wrong words for the first
  // N attempts, and junk on readdata outside the exact latency slot.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rdata[i] = JUNK; wr[i] = 1'b0; id_reads[i] = 0; st_cnt[i] = 0; pend[i] = 0; pdata[i] = JUNK;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] w;
        rdata[i] = JUNK;
        wr[i] = 1'b0;
        if (pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) rdata[i] = pdata[i];
        end
        if (!reset_n) begin
          st_cnt[i] = 0; pend[i] = 0;
        end else if (!rd[i]) begin
          st_cnt[i] = 0;
        end else if (st_cnt[i] < (addr[i] ? st_ts[i] : st_id[i])) begin
          wr[i] = 1'b1;
          st_cnt[i]++;
        end else begin
          st_cnt[i] = 0;
          if (addr[i]) w = ((id_reads[i] - base[i] - 1) < ts_bad[i]) ? BAD_TS : EXP_TS;
          else begin
            w = ((id_reads[i] - base[i]) < id_bad[i]) ? BAD_ID : EXP_ID;
            id_reads[i]++;
          end
          if (rl(i) == 0) rdata[i] = w;
          else begin pend[i] = rl(i); pdata[i] = w; end
        end
      end
    end
  end

  // Scoreboard: each done pops the oldest expectation for that instance.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      if (reset_n && done[i] === 1'b1) begin
        int k;
        vec_t e;
        k = -1;
        foreach (sb[j]) if (k < 0 && sb[j].inst == i) k = j;
        if (k < 0) chk($sformatf("unexpected_done_%0d", i), 32'(done[i]), 32'd0);
        else begin
          e = sb[k];
          sb.delete(k);
          chk($sformatf("pass_%0d", i), 32'(pass[i]), 32'(e.pass));
          chk($sformatf("err_id_%0d", i), 32'(err_id[i]), 32'(e.eid));
          chk($sformatf("err_ts_%0d", i), 32'(err_ts[i]), 32'(e.ets));
          chk($sformatf("err_timeout_%0d", i), 32'(err_timeout[i]), 32'(e.etmo));
          chk($sformatf("read_pairs_%0d", i), 32'(id_reads[i] - base[i]), 32'(e.pairs));
          chk($sformatf("read_idle_at_done_%0d", i), 32'(rd[i]), 32'd0);
          if (e.chkv) begin
            chk($sformatf("id_value_%0d", i), id_value[i], e.idv);
            chk($sformatf("ts_value_%0d", i), ts_value[i], e.tsv);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t good [2];
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      good[i] = mk(i, 0,0, 0,0, 1,0,0,0, 1, 1, EXP_ID, EXP_TS);
    end
    tbl.push_back(mk(0,  0, 0,   0,   0, 1,0,0,0, 1, 1, EXP_ID, EXP_TS));
    tbl.push_back(mk(0, 99, 0,   0,   0, 0,1,0,0, 3, 1, BAD_ID, EXP_TS));
    tbl.push_back(mk(0,  1, 0,   0,   0, 1,0,0,0, 2, 1, EXP_ID, EXP_TS));
    tbl.push_back(mk(0,  0,99,   0,   0, 0,0,1,0, 3, 1, EXP_ID, BAD_TS));
    tbl.push_back(mk(0,  2, 3,   0,   0, 0,0,1,0, 3, 1, EXP_ID, BAD_TS));
    tbl.push_back(mk(0,  0, 0,   0, 255, 0,0,0,1, 1, 0, EXP_ID, EXP_TS));
    tbl.push_back(mk(0,  0, 0,   0, 254, 1,0,0,0, 1, 1, EXP_ID, EXP_TS));
    tbl.push_back(mk(0,  0, 0, 255,   0, 0,0,0,1, 0, 0, EXP_ID, EXP_TS));
    tbl.push_back(mk(0,  3, 0,   2,   1, 0,1,0,0, 3, 1, BAD_ID, EXP_TS));
    tbl.push_back(mk(1,  0, 0,   3,   0, 1,0,0,0, 1, 1, EXP_ID, EXP_TS));
    tbl.push_back(mk(1,  2, 0,   0,   0, 1,0,0,0, 3, 1, EXP_ID, EXP_TS));
    tbl.push_back(mk(1, 99, 0,   0,   0, 0,1,0,0, 3, 1, BAD_ID, EXP_TS));
    tbl.push_back(mk(1,  0, 0,   0, 255, 0,0,0,1, 1, 0, EXP_ID, EXP_TS));
    tbl.push_back(mk(1,  0, 1,   1,   2, 1,0,0,0, 2, 1, EXP_ID, EXP_TS));

    // Reset state, then the automatic run with exact cycle timing on instance 0.
    for (int i = 0; i < 2; i++) set_cfg(i, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy_%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done_%0d", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_pass_%0d", i), 32'(pass[i]), 32'd0);
      chk($sformatf("rst_errs_%0d", i), {29'd0, err_id[i], err_ts[i], err_timeout[i]}, 32'd0);
      chk($sformatf("rst_read_%0d", i), {30'd0, rd[i], addr[i]}, 32'd0);
      chk($sformatf("rst_id_value_%0d", i), id_value[i], 32'd0);
      chk($sformatf("rst_ts_value_%0d", i), ts_value[i], 32'd0);
    end
    sb.push_back(good[0]);
    sb.push_back(good[1]);
    reset_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      chk($sformatf("auto_busy_c%0d", c), 32'(busy[0]), 32'(c < 4));
      chk($sformatf("auto_done_c%0d", c), 32'(done[0]), 32'(c == 4));
      chk($sformatf("auto_read_c%0d", c), 32'(rd[0]), 32'(c <= 2));
      if (c <= 2) chk($sformatf("auto_addr_c%0d", c), 32'(addr[0]), 32'(c == 2));
    end
    wait_idle(100);

    foreach (tbl[k]) run_vec(tbl[k]);

    // start while busy and during DONE must be dropped.
    set_cfg(0, 0, 0, 0, 0);
    sb.push_back(good[0]);
    @(negedge clock);
    start[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      start[0] = (c == 2 || c == 4);
    end
    start[0] = 1'b0;
    chk("ignored_start_queue", 32'(sb.size()), 32'd0);
    chk("ignored_start_idle", 32'(busy[0]), 32'd0);

    // Reset during LAT_ID (instance 1) while instance 0 is stalled in RD_ID.
    set_cfg(0, 0, 0, 1000, 0);
    set_cfg(1, 0, 0, 0, 0);
    @(negedge clock);
    start[0] = 1'b1; start[1] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0; start[1] = 1'b0;
    @(negedge clock);
    chk("pre_rst_read_0", 32'(rd[0]), 32'd1);
    chk("pre_rst_busy_1", 32'(busy[1]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_read_0", 32'(rd[0]), 32'd0);
    chk("async_rst_busy_0", 32'(busy[0]), 32'd0);
    chk("async_rst_read_1", 32'(rd[1]), 32'd0);
    chk("async_rst_busy_1", 32'(busy[1]), 32'd0);
    chk("async_rst_pass_1", 32'(pass[1]), 32'd0);
    sb.delete();
    @(negedge clock);
    for (int i = 0; i < 2; i++) set_cfg(i, 0, 0, 0, 0);
    sb.push_back(good[0]);
    sb.push_back(good[1]);
    @(negedge clock);
    reset_n = 1'b1;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
